bankgroup_scheduler: RTL and testbench

Request scheduler in front of one bank group (2**BAWIDTH banks). It accepts single-beat read and write requests and tracks the open row of every bank. For each bank it runs an activate/precharge state machine that enforces tRCD and tRP, drives the group's per-bank rd_o_wr/dqin/row/column buses, and returns read data after a fixed read latency.

---
 rtl/bankgroup_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_bankgroup_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bankgroup_scheduler.sv
// Single-entry request scheduler for one bank group with per-bank ACT/PRE timing.
// Optional closed-page mode: define BGSCHED_AUTOPRE_EN.
module bankgroup_scheduler #(
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int RD_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [BAWIDTH-1:0]      req_bank,
  input  logic [CHWIDTH-1:0]      req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic [DEVICE_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [DEVICE_WIDTH-1:0] rsp_data,
  output logic [0:0]              bg_rd_o_wr [2**BAWIDTH],
  output logic [DEVICE_WIDTH-1:0] bg_dqin    [2**BAWIDTH],
  input  logic [DEVICE_WIDTH-1:0] bg_dqout   [2**BAWIDTH],
  output logic [CHWIDTH-1:0]      bg_row     [2**BAWIDTH],
  output logic [COLWIDTH-1:0]     bg_column  [2**BAWIDTH]
);
  localparam int BANKS = 2**BAWIDTH;
  localparam int CW    = $clog2(T_RCD + T_RP + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACT  = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;
  localparam logic [1:0] S_PRE  = 2'd3;

  logic                    hr_valid_q;
  logic                    hr_wr_q;
  logic [BAWIDTH-1:0]      hr_bank_q;
  logic [CHWIDTH-1:0]      hr_row_q;
  logic [COLWIDTH-1:0]     hr_col_q;
  logic [DEVICE_WIDTH-1:0] hr_wdata_q;

  logic [1:0]         st_q  [BANKS];
  logic [1:0]         st_d  [BANKS];
  logic [CW-1:0]      cnt_q [BANKS];
  logic [CW-1:0]      cnt_d [BANKS];
  logic [CHWIDTH-1:0] row_q [BANKS];
  logic [CHWIDTH-1:0] row_d [BANKS];
  logic [BANKS-1:0]   tgt;
  logic               issue;
  logic               accept;

  logic [0:0]              bgwr_q  [BANKS];
  logic [DEVICE_WIDTH-1:0] bgdq_q  [BANKS];
  logic [CHWIDTH-1:0]      bgrow_q [BANKS];
  logic [COLWIDTH-1:0]     bgcol_q [BANKS];

  logic [RD_LAT-1:0]  rd_vld_q;
  logic [BAWIDTH-1:0] rd_bank_q [RD_LAT];
  logic               rsp_valid_q;
  logic [DEVICE_WIDTH-1:0] rsp_data_q;

  always_comb begin
    tgt = '0;
    for (int unsigned b = 0; b < BANKS; b++)
      tgt[b] = hr_valid_q && (hr_bank_q == BAWIDTH'(b));
  end

  // The final ACT cycle issues the pending access directly, so a miss costs 1+T_RCD.
  always_comb begin
    issue = 1'b0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      st_d[b]  = st_q[b];
      cnt_d[b] = cnt_q[b];
      row_d[b] = row_q[b];
      case (st_q[b])
        S_IDLE: if (tgt[b]) begin
          st_d[b]  = S_ACT;
          cnt_d[b] = CW'(T_RCD - 1);
          row_d[b] = hr_row_q;
        end
        S_ACT: if (cnt_q[b] == '0) begin
          st_d[b] = S_OPEN;
          if (tgt[b] && row_q[b] == hr_row_q) issue = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] - 1'b1;
        end
        S_OPEN: if (tgt[b]) begin
          if (row_q[b] == hr_row_q) begin
            issue = 1'b1;
          end else begin
            st_d[b]  = S_PRE;
            cnt_d[b] = CW'(T_RP - 1);
          end
        end
        default: if (cnt_q[b] == '0) st_d[b] = S_IDLE;
                 else cnt_d[b] = cnt_q[b] - 1'b1;
      endcase
`ifdef BGSCHED_AUTOPRE_EN
      if (issue && tgt[b]) begin
        st_d[b]  = S_PRE;
        cnt_d[b] = CW'(T_RP - 1);
      end
`endif
    end
  end

  assign req_ready = !hr_valid_q || issue;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr_valid_q <= 1'b0;
      hr_wr_q    <= 1'b0;
      hr_bank_q  <= '0;
      hr_row_q   <= '0;
      hr_col_q   <= '0;
      hr_wdata_q <= '0;
    end else if (accept) begin
      hr_valid_q <= 1'b1;
      hr_wr_q    <= req_wr;
      hr_bank_q  <= req_bank;
      hr_row_q   <= req_row;
      hr_col_q   <= req_col;
      hr_wdata_q <= req_wdata;
    end else if (issue) begin
      hr_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        st_q[b]    <= S_IDLE;
        cnt_q[b]   <= '0;
        row_q[b]   <= '0;
        bgwr_q[b]  <= '0;
        bgdq_q[b]  <= '0;
        bgrow_q[b] <= '0;
        bgcol_q[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        st_q[b]   <= st_d[b];
        cnt_q[b]  <= cnt_d[b];
        row_q[b]  <= row_d[b];
        bgwr_q[b] <= '0;
      end
      if (issue) begin
        bgrow_q[hr_bank_q] <= row_q[hr_bank_q];
        bgcol_q[hr_bank_q] <= hr_col_q;
        if (hr_wr_q) begin
          bgwr_q[hr_bank_q] <= 1'b1;
          bgdq_q[hr_bank_q] <= hr_wdata_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) rd_bank_q[i] <= '0;
    end else begin
      rd_vld_q[0]  <= issue && !hr_wr_q;
      rd_bank_q[0] <= hr_bank_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_bank_q[i] <= rd_bank_q[i-1];
      end
      rsp_valid_q <= rd_vld_q[RD_LAT-1];
      if (rd_vld_q[RD_LAT-1]) rsp_data_q <= bg_dqout[rd_bank_q[RD_LAT-1]];
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign bg_rd_o_wr = bgwr_q;
  assign bg_dqin    = bgdq_q;
  assign bg_row     = bgrow_q;
  assign bg_column  = bgcol_q;
endmodule

// File: tb/tb_bankgroup_scheduler.sv
// Directed plus random requests against a latency/row-state reference model and bank memory.
module tb_bankgroup_scheduler;
  localparam int BA = 2, NB = 4, CO = 10, CH = 5, DW = 4;
  localparam int T_RCD = 2, T_RP = 2, RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_wr = 1'b0;
  logic req_ready;
  logic [BA-1:0] req_bank = '0;
  logic [CH-1:0] req_row = '0;
  logic [CO-1:0] req_col = '0;
  logic [DW-1:0] req_wdata = '0;
  logic rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [0:0]    bg_rd_o_wr [NB];
  logic [DW-1:0] bg_dqin    [NB];
  logic [DW-1:0] bg_dqout   [NB];
  logic [CH-1:0] bg_row     [NB];
  logic [CO-1:0] bg_column  [NB];

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  logic [DW-1:0] envmem [NB][8][16];
  logic [DW-1:0] refmem [NB][8][16];
  bit            open_v [NB];
  int            open_r [NB];

  always #5 clk = ~clk;

  bankgroup_scheduler #(.BAWIDTH(BA), .COLWIDTH(CO), .CHWIDTH(CH), .DEVICE_WIDTH(DW),
                        .T_RCD(T_RCD), .T_RP(T_RP), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .bg_rd_o_wr(bg_rd_o_wr), .bg_dqin(bg_dqin),
    .bg_dqout(bg_dqout), .bg_row(bg_row), .bg_column(bg_column));

  // Bank array behaviour: combinational read of the addressed cell, write on the strobe edge.
  always_comb
    for (int b = 0; b < NB; b++)
      bg_dqout[b] = envmem[b][bg_row[b][2:0]][bg_column[b][3:0]];

  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (bg_rd_o_wr[b] === 1'b1) envmem[b][bg_row[b][2:0]][bg_column[b][3:0]] <= bg_dqin[b];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rspd"}, 32'(rsp_data), 32'd0);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("%s_wr%0d", tag, b), 32'(bg_rd_o_wr[b]), 32'd0);
      check($sformatf("%s_dq%0d", tag, b), 32'(bg_dqin[b]), 32'd0);
      check($sformatf("%s_row%0d", tag, b), 32'(bg_row[b]), 32'd0);
      check($sformatf("%s_col%0d", tag, b), 32'(bg_column[b]), 32'd0);
    end
  endtask

  // Latency from the accept edge to the access edge follows from the bank's row state alone.
  task automatic do_req(input string tag, input bit wr, input int bank, input int row,
                        input int col, input int dat);
    int lat;
    logic [DW-1:0] exp_rd;
`ifdef BGSCHED_AUTOPRE_EN
    lat = 1 + T_RCD;
`else
    if (!open_v[bank])         lat = 1 + T_RCD;
    else if (open_r[bank] == row) lat = 1;
    else                       lat = 2 + T_RP + T_RCD;
`endif
    exp_rd = refmem[bank][row][col];
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_bank = BA'(bank); req_row = CH'(row);
    req_col = CO'(col); req_wdata = DW'(dat);
    check({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k <= lat + RD_LAT + 1; k++) begin
      check($sformatf("%s_ready_k%0d", tag, k), 32'(req_ready), 32'(k >= lat - 1));
      for (int b = 0; b < NB; b++)
        check($sformatf("%s_wr%0d_k%0d", tag, b, k), 32'(bg_rd_o_wr[b]),
              32'(wr && k == lat && b == bank));
      if (k == lat) begin
        check({tag, "_row"}, 32'(bg_row[bank]), 32'(row));
        check({tag, "_col"}, 32'(bg_column[bank]), 32'(col));
        if (wr) check({tag, "_dqin"}, 32'(bg_dqin[bank]), 32'(dat));
      end
      check($sformatf("%s_rspv_k%0d", tag, k), 32'(rsp_valid), 32'(!wr && k == lat + RD_LAT));
      if (!wr && k == lat + RD_LAT) check({tag, "_rspd"}, 32'(rsp_data), 32'(exp_rd));
      @(posedge clk); #1;
    end
    if (wr) refmem[bank][row][col] = DW'(dat);
`ifndef BGSCHED_AUTOPRE_EN
    open_v[bank] = 1'b1;
    open_r[bank] = row;
`endif
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      open_v[b] = 1'b0; open_r[b] = 0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 16; c++) begin
          envmem[b][r][c] = '0; refmem[b][r][c] = '0;
        end
    end
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    do_req("wr_miss",    1'b1, 1, 3, 5, 4'hA);
    do_req("rd_hit",     1'b0, 1, 3, 5, 0);
    do_req("rd_conflict",1'b0, 1, 4, 5, 0);
    do_req("il_b0",      1'b1, 0, 2, 7, 4'h3);
    do_req("il_b2",      1'b1, 2, 5, 1, 4'hC);
    do_req("il_b0_hit",  1'b1, 0, 2, 8, 4'h9);
    do_req("il_b2_rd",   1'b0, 2, 5, 1, 0);

    // Reset while bank 3 is activating for a read.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_bank = 2'd3; req_row = 5'd1; req_col = 10'd1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check_outputs_zero("midrst");
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_rspv_%0d", k), 32'(rsp_valid), 32'd0);
    end
    for (int b = 0; b < NB; b++) open_v[b] = 1'b0;
    do_req("postrst_rd", 1'b0, 3, 1, 1, 0);
    do_req("postrst_rd2",1'b0, 3, 1, 1, 0);

    for (int n = 0; n < 40; n++)
      do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
